// File: rtl/rs232_receiver.sv
// 8N1 receiver for the host RS232 TXD line: deserializes frames, presents each byte
// on a valid/ready handshake and drives CTS flow control back to the host.
module rs232_receiver #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rs232_txd,
  output logic       rs232_cts_n,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
);

  // Mid-bit sample offset for bit k of a frame, measured in clocks from start detect.
  function automatic longint sample_offset(input logic [3:0] k);
    return (longint'(CLOCK_FREQ) * longint'({k, 1'b1})) / (longint'(BAUD_RATE) * 64'sd2);
  endfunction

  localparam longint S_LAST = sample_offset(4'd9);
  localparam int     CNT_W  = $clog2(S_LAST) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [CNT_W-1:0] S_TAB [10] = '{
    CNT_W'(sample_offset(4'd0)), CNT_W'(sample_offset(4'd1)),
    CNT_W'(sample_offset(4'd2)), CNT_W'(sample_offset(4'd3)),
    CNT_W'(sample_offset(4'd4)), CNT_W'(sample_offset(4'd5)),
    CNT_W'(sample_offset(4'd6)), CNT_W'(sample_offset(4'd7)),
    CNT_W'(sample_offset(4'd8)), CNT_W'(sample_offset(4'd9))
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic             sync1_r;
  logic             sync2_r;
  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             armed_r;

  logic [CNT_W-1:0] target_s;
  logic             sample_s;
  logic             frame_done_s;
  logic             stop_ok_s;
  logic             stop_bad_s;
  logic             load_s;
  logic             valid_next_s;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rs232_txd;
      sync2_r <= sync1_r;
    end
  end

  // Select the sample offset for the bit currently being received.
  always_comb begin
    target_s = S_TAB[4'd9];
    case (bit_idx_r)
      4'd0:    target_s = S_TAB[4'd0];
      4'd1:    target_s = S_TAB[4'd1];
      4'd2:    target_s = S_TAB[4'd2];
      4'd3:    target_s = S_TAB[4'd3];
      4'd4:    target_s = S_TAB[4'd4];
      4'd5:    target_s = S_TAB[4'd5];
      4'd6:    target_s = S_TAB[4'd6];
      4'd7:    target_s = S_TAB[4'd7];
      4'd8:    target_s = S_TAB[4'd8];
      default: target_s = S_TAB[4'd9];
    endcase
  end

  // Sample strobes, stop-bit outcome and next handshake state.
  always_comb begin
    sample_s     = (state_r == ST_RUN) && (count_r == target_s);
    frame_done_s = sample_s && (bit_idx_r == 4'd9);
    stop_ok_s    = frame_done_s && sync2_r;
    stop_bad_s   = frame_done_s && !sync2_r;
    load_s       = stop_ok_s && (!valid || ready);
    if (load_s) begin
      valid_next_s = 1'b1;
    end else if (valid && ready) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid;
    end
  end

  // Frame FSM: start detection, per-bit sampling and LSB-first shifting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      bit_idx_r <= 4'd0;
      shift_r   <= 8'h00;
      armed_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_r   <= CNT_ZERO;
          bit_idx_r <= 4'd0;
          // A break must see the line high again before the next frame can start.
          if (sync2_r) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          count_r <= count_r + CNT_ONE;
          if (sample_s) begin
            if (bit_idx_r == 4'd0) begin
              if (sync2_r) begin
                state_r <= ST_IDLE;
              end else begin
                bit_idx_r <= 4'd1;
              end
            end else if (bit_idx_r == 4'd9) begin
              state_r <= ST_IDLE;
              armed_r <= 1'b0;
            end else begin
              shift_r   <= {sync2_r, shift_r[7:1]};
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Output register: holding buffer, error pulses and CTS that mirrors buffer occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      rs232_cts_n   <= 1'b1;
    end else begin
      framing_error <= stop_bad_s;
      overrun       <= stop_ok_s && valid && !ready;
      valid         <= valid_next_s;
      rs232_cts_n   <= valid_next_s;
      if (load_s) begin
        data <= shift_r;
      end
    end
  end

endmodule

// File: tb/tb_rs232_receiver.sv
// Bench for rs232_receiver: two instances (integer and fractional clock/baud ratio),
// a waveform-history model and directed frame scenarios with literal expectations.
module tb_rs232_receiver;

  localparam int CF0 = 1600;
  localparam int BR0 = 100;
  localparam int CF1 = 1000;
  localparam int BR1 = 70;

  logic       clock = 1'b0;
  logic       reset_v [2];
  logic       txd     [2];
  logic       ready_v [2];
  logic       cts_n   [2];
  logic [7:0] data_o  [2];
  logic       valid_o [2];
  logic       fe_o    [2];
  logic       ov_o    [2];

  always #5 clock = ~clock;

  rs232_receiver #(.CLOCK_FREQ(CF0), .BAUD_RATE(BR0)) u0 (
    .clock(clock), .reset(reset_v[0]), .rs232_txd(txd[0]), .rs232_cts_n(cts_n[0]),
    .data(data_o[0]), .valid(valid_o[0]), .ready(ready_v[0]),
    .framing_error(fe_o[0]), .overrun(ov_o[0])
  );

  rs232_receiver #(.CLOCK_FREQ(CF1), .BAUD_RATE(BR1)) u1 (
    .clock(clock), .reset(reset_v[1]), .rs232_txd(txd[1]), .rs232_cts_n(cts_n[1]),
    .data(data_o[1]), .valid(valid_o[1]), .ready(ready_v[1]),
    .framing_error(fe_o[1]), .overrun(ov_o[1])
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int s_tab [2][10];

  // model state: recorded line history plus the abstract receiver outcome
  bit         line_h [2][0:65535];
  bit         m_busy [2];
  bit         m_armed[2];
  int         m_d    [2];
  logic       m_valid[2];
  logic [7:0] m_data [2];
  logic       m_fe   [2];
  logic       m_ov   [2];
  logic       m_cts  [2];

  // observations of the DUT
  int         rise_cnt [2];
  int         rise_n   [2];
  logic [7:0] rise_data[2];
  int         fe_cnt   [2];
  int         ov_cnt   [2];
  int         vhigh_cnt[2];
  int         cts_cnt  [2];
  logic       prev_valid[2];
  logic [7:0] prev_data [2];
  int         cons_cnt = 0;
  logic [7:0] sb_q[$];
  int         last_e0[2];
  bit         rr_on = 1'b0;

  function automatic int s_off(input int cf, input int br, input int k);
    return int'((longint'(cf) * longint'(2 * k + 1)) / longint'(2 * br));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_step(input int i);
    logic s;
    logic load;
    logic [7:0] b;
    int off;
    if (reset_v[i]) begin
      line_h[i][n] = 1'b1;
      if (n > 0) line_h[i][n-1] = 1'b1;
      m_busy[i] = 1'b0; m_armed[i] = 1'b0;
      m_valid[i] = 1'b0; m_data[i] = 8'h00;
      m_fe[i] = 1'b0; m_ov[i] = 1'b0; m_cts[i] = 1'b1;
    end else begin
      line_h[i][n] = txd[i];
      s = (n >= 2) ? line_h[i][n-2] : 1'b1;
      m_fe[i] = 1'b0; m_ov[i] = 1'b0; load = 1'b0; b = 8'h00;
      if (m_busy[i]) begin
        off = n - m_d[i] - 1;
        if (off == s_tab[i][0] && s) begin
          m_busy[i] = 1'b0;
        end else if (off == s_tab[i][9]) begin
          for (int k = 1; k <= 8; k++) b[k-1] = line_h[i][m_d[i] - 1 + s_tab[i][k]];
          m_busy[i] = 1'b0; m_armed[i] = 1'b0;
          if (!s) m_fe[i] = 1'b1;
          else if (!m_valid[i] || ready_v[i]) load = 1'b1;
          else m_ov[i] = 1'b1;
        end
      end else if (s) begin
        m_armed[i] = 1'b1;
      end else if (m_armed[i]) begin
        m_busy[i] = 1'b1;
        m_d[i] = n;
      end
      if (load) begin
        m_valid[i] = 1'b1;
        m_data[i] = b;
      end else if (m_valid[i] && ready_v[i]) begin
        m_valid[i] = 1'b0;
      end
      m_cts[i] = m_valid[i];
    end
  endtask

  task automatic compare(input int i);
    if (errors < 100)
      chk((i == 0) ? "outs_u0" : "outs_u1",
          {cts_n[i], valid_o[i], data_o[i], fe_o[i], ov_o[i]},
          {m_cts[i], m_valid[i], m_data[i], m_fe[i], m_ov[i]});
    if (i == 1 && !reset_v[1] && prev_valid[1] && ready_v[1]) begin
      cons_cnt++;
      if (sb_q.size() == 0) chk("sb_extra_byte", 1, 0);
      else chk("sb_order", prev_data[1], sb_q.pop_front());
    end
    if (valid_o[i] && !prev_valid[i]) begin
      rise_cnt[i]++;
      rise_n[i] = n;
      rise_data[i] = data_o[i];
    end
    fe_cnt[i] += fe_o[i];
    ov_cnt[i] += ov_o[i];
    vhigh_cnt[i] += valid_o[i];
    cts_cnt[i] += cts_n[i];
    prev_valid[i] = valid_o[i];
    prev_data[i] = data_o[i];
  endtask

  // Model and compare process: model at the edge, check the DUT 1 time unit later.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; rise_n[i] = 0; rise_data[i] = 8'h00; fe_cnt[i] = 0; ov_cnt[i] = 0;
      vhigh_cnt[i] = 0; cts_cnt[i] = 0; prev_valid[i] = 1'b0; prev_data[i] = 8'h00;
      m_busy[i] = 1'b0; m_armed[i] = 1'b0; m_d[i] = 0; last_e0[i] = 0;
      for (int k = 0; k < 10; k++)
        s_tab[i][k] = (i == 0) ? s_off(CF0, BR0, k) : s_off(CF1, BR1, k);
    end
    forever begin
      @(posedge clock);
      for (int i = 0; i < 2; i++) model_step(i);
      #1;
      for (int i = 0; i < 2; i++) compare(i);
      n = n + 1;
    end
  end

  // Random ready for the fractional-ratio stream.
  initial forever begin
    @(negedge clock);
    if (rr_on) ready_v[1] = 1'($urandom_range(0, 1));
  end

  initial begin
    #800000;
    $display("FAIL watchdog: cycle budget exceeded at cycle %0d", n);
    $fatal(1);
  end

  task automatic idle(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      txd[i] = 1'b1;
    end
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic stopv);
    int cf, br;
    logic v;
    cf = (i == 0) ? CF0 : CF1;
    br = (i == 0) ? BR0 : BR1;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : ((k == 9) ? stopv : b[k-1]);
      for (int c = k * cf / br; c < (k + 1) * cf / br; c++) begin
        @(negedge clock);
        txd[i] = v;
        if (k == 0 && c == 0) last_e0[i] = n;
      end
    end
  endtask

  int r0, f0, o0, vh0, c0;
  logic [7:0] rb;

  initial begin
    reset_v[0] = 1'b1; reset_v[1] = 1'b1;
    txd[0] = 1'b1; txd[1] = 1'b1;
    ready_v[0] = 1'b1; ready_v[1] = 1'b1;
    @(negedge clock);
    chk("rst_valid", valid_o[0], 0);
    chk("rst_cts_n", cts_n[0], 1);
    chk("rst_data", data_o[0], 0);
    chk("rst_pulses", {fe_o[0], ov_o[0]}, 0);
    repeat (2) @(negedge clock);
    reset_v[0] = 1'b0; reset_v[1] = 1'b0;
    idle(0, 10);

    // 0x55 with ready held high
    r0 = rise_cnt[0]; f0 = fe_cnt[0]; o0 = ov_cnt[0]; vh0 = vhigh_cnt[0]; c0 = cts_cnt[0];
    send(0, 8'h55, 1'b1);
    idle(0, 20);
    chk("t1_latency", rise_n[0] - last_e0[0], 155);
    chk("t1_data", rise_data[0], 8'h55);
    chk("t1_rises", rise_cnt[0] - r0, 1);
    chk("t1_valid_cycles", vhigh_cnt[0] - vh0, 1);
    chk("t1_cts_cycles", cts_cnt[0] - c0, 1);
    chk("t1_errors", (fe_cnt[0] - f0) + (ov_cnt[0] - o0), 0);

    // back-to-back 0xA3, 0x0F with ready low
    ready_v[0] = 1'b0;
    r0 = rise_cnt[0]; o0 = ov_cnt[0];
    send(0, 8'hA3, 1'b1);
    send(0, 8'h0F, 1'b1);
    idle(0, 10);
    chk("t2_overrun", ov_cnt[0] - o0, 1);
    chk("t2_rises", rise_cnt[0] - r0, 1);
    chk("t2_data_held", data_o[0], 8'hA3);
    chk("t2_valid_held", valid_o[0], 1);
    chk("t2_cts_held", cts_n[0], 1);
    ready_v[0] = 1'b1;
    @(negedge clock);
    chk("t2_consumed_valid", valid_o[0], 0);
    chk("t2_consumed_cts", cts_n[0], 0);

    // idle glitch then 0x7E
    r0 = rise_cnt[0]; f0 = fe_cnt[0];
    idle(0, 20);
    repeat (5) begin
      @(negedge clock);
      txd[0] = 1'b0;
    end
    idle(0, 30);
    chk("t3_glitch_rises", rise_cnt[0] - r0, 0);
    send(0, 8'h7E, 1'b1);
    idle(0, 20);
    chk("t3_fe", fe_cnt[0] - f0, 0);
    chk("t3_rises", rise_cnt[0] - r0, 1);
    chk("t3_data", rise_data[0], 8'h7E);

    // 0xC4 with stop low, then a 40-bit break, then 0x31 held (ready low)
    r0 = rise_cnt[0]; f0 = fe_cnt[0];
    send(0, 8'hC4, 1'b0);
    repeat (640) begin
      @(negedge clock);
      txd[0] = 1'b0;
    end
    chk("t4_break_fe", fe_cnt[0] - f0, 1);
    chk("t4_break_rises", rise_cnt[0] - r0, 0);
    ready_v[0] = 1'b0;
    idle(0, 40);
    send(0, 8'h31, 1'b1);
    idle(0, 20);
    chk("t4_rises", rise_cnt[0] - r0, 1);
    chk("t4_data", rise_data[0], 8'h31);
    chk("t4_fe_total", fe_cnt[0] - f0, 1);
    chk("t4_valid_held", valid_o[0], 1);

    // reset at counter 60 of an 0xFC frame, then 0x99
    r0 = rise_cnt[0]; f0 = fe_cnt[0]; o0 = ov_cnt[0];
    fork
      send(0, 8'hFC, 1'b1);
      begin
        @(negedge clock);
        repeat (63) @(negedge clock);
        reset_v[0] = 1'b1;
        @(negedge clock);
        chk("t6_rst_valid", valid_o[0], 0);
        chk("t6_rst_cts_n", cts_n[0], 1);
        chk("t6_rst_pulses", {fe_o[0], ov_o[0]}, 0);
        reset_v[0] = 1'b0;
      end
    join
    idle(0, 40);
    chk("t6_abort_rises", rise_cnt[0] - r0, 0);
    ready_v[0] = 1'b1;
    send(0, 8'h99, 1'b1);
    idle(0, 20);
    chk("t6_rises", rise_cnt[0] - r0, 1);
    chk("t6_data", rise_data[0], 8'h99);
    chk("t6_errors", (fe_cnt[0] - f0) + (ov_cnt[0] - o0), 0);

    // fractional ratio: 200 random bytes, 1-cycle gaps, random ready
    r0 = rise_cnt[1]; f0 = fe_cnt[1]; o0 = ov_cnt[1];
    rr_on = 1'b1;
    for (int j = 0; j < 200; j++) begin
      rb = 8'($urandom_range(0, 255));
      sb_q.push_back(rb);
      send(1, rb, 1'b1);
      idle(1, 1);
    end
    idle(1, 200);
    rr_on = 1'b0;
    @(negedge clock);
    ready_v[1] = 1'b1;
    idle(1, 10);
    chk("t5_consumed", cons_cnt, 200);
    chk("t5_queue_left", sb_q.size(), 0);
    chk("t5_rises", rise_cnt[1] - r0, 200);
    chk("t5_errors", (fe_cnt[1] - f0) + (ov_cnt[1] - o0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
